// File: rtl/clk_step_ctrl.sv
// Core clock-step controller: HALT/RUN/STEP states, programmable tick divider.
// Optional tick counter enabled by defining CLK_STEP_CYCLE_CNT_EN.
module clk_step_ctrl #(
  parameter logic [27:0] DEFAULT_DIV = 28'd2
) (
  input  logic        clock_in,
  input  logic        rst,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic [27:0] cfg_div,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic        tick,
  output logic [1:0]  state,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_run_prev;
  logic        r_halt_prev;
  logic        r_step_prev;
  logic [27:0] r_div;
  logic [27:0] r_phase;
  logic [27:0] w_phase_nxt;
  logic [27:0] w_div_eff;
  logic        w_run_edge;
  logic        w_halt_edge;
  logic        w_step_edge;
  logic        w_tick;
  logic        w_cfg_load;

  // History flops reset high so a request held across reset release is not an edge.
  always_ff @(posedge clock_in or posedge rst) begin
    if (rst) begin
      r_state     <= ST_HALT;
      r_run_prev  <= 1'b1;
      r_halt_prev <= 1'b1;
      r_step_prev <= 1'b1;
      r_phase     <= '0;
      r_div       <= DEFAULT_DIV;
    end else begin
      r_state     <= w_state_nxt;
      r_run_prev  <= run_req;
      r_halt_prev <= halt_req;
      r_step_prev <= step_req;
      r_phase     <= w_phase_nxt;
      if (w_cfg_load) r_div <= cfg_div;
    end
  end

  always_comb begin
    w_run_edge  = run_req & ~r_run_prev;
    w_halt_edge = halt_req & ~r_halt_prev;
    w_step_edge = step_req & ~r_step_prev;
    w_div_eff   = (r_div > 28'd1) ? r_div : 28'd1;
    w_tick      = (r_state != ST_HALT) && (r_phase == (w_div_eff - 28'd1));
    w_state_nxt = r_state;
    case (r_state)
      ST_HALT: begin
        if (w_halt_edge)      w_state_nxt = ST_HALT;
        else if (w_step_edge) w_state_nxt = ST_STEP;
        else if (w_run_edge)  w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_halt_edge) w_state_nxt = ST_HALT;
      end
      ST_STEP: begin
        if (w_halt_edge || w_tick) w_state_nxt = ST_HALT;
      end
      default: w_state_nxt = ST_HALT;
    endcase
    // Counter only advances while staying in an active state; any exit or wrap clears it.
    if ((r_state != ST_HALT) && (w_state_nxt == r_state) && !w_tick)
      w_phase_nxt = r_phase + 28'd1;
    else
      w_phase_nxt = '0;
  end

  assign tick       = w_tick;
  assign state      = r_state;
  assign cfg_ready  = (r_state == ST_HALT);
  assign w_cfg_load = cfg_valid & cfg_ready;

`ifdef CLK_STEP_CYCLE_CNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clock_in or posedge rst) begin
    if (rst)         r_cycle_count <= '0;
    else if (w_tick) r_cycle_count <= r_cycle_count + 32'd1;
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Scoreboard bench for clk_step_ctrl: stimulus queues expected ticks, a monitor
// pops and compares on every tick.
module tb_clk_step_ctrl;

`ifdef CLK_STEP_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock_in = 1'b0;
  logic        rst;
  logic        run_req;
  logic        halt_req;
  logic        step_req;
  logic [27:0] cfg_div;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        tick;
  logic [1:0]  state;
  logic [31:0] cycle_count;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          c;
  logic [31:0] exp_cnt = '0;

  typedef struct {
    int          at;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  clk_step_ctrl #(.DEFAULT_DIV(28'd2)) dut (
    .clock_in    (clock_in),
    .rst         (rst),
    .run_req     (run_req),
    .halt_req    (halt_req),
    .step_req    (step_req),
    .cfg_div     (cfg_div),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .tick        (tick),
    .state       (state),
    .cycle_count (cycle_count)
  );

  always #5 clock_in = ~clock_in;
  always @(posedge clock_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_tick(input int at);
    exp_t e;
    e.at  = at;
    e.cnt = CNT_EN ? exp_cnt : 32'd0;
    sb.push_back(e);
    exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic tick1();
    @(posedge clock_in);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) tick1();
  endtask

  task automatic drain(input string name);
    tick1();
    tick1();
    check(name, sb.size(), 0);
  endtask

  task automatic load_div(input logic [27:0] d);
    cfg_div   = d;
    cfg_valid = 1'b1;
    tick1();
    cfg_valid = 1'b0;
  endtask

  always @(negedge clock_in) begin
    if (tick === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_tick", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("tick_cycle", cyc, mon_e.at);
        check("tick_count", cycle_count, mon_e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    cfg_valid = 1'b0; cfg_div = '0;
    repeat (3) tick1();
    check("rst_state", state, 2'b00);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_tick", tick, 0);
    check("rst_count", cycle_count, 0);
    rst = 1'b0;
    tick1();

    // Default divisor 2, free run, halt on a tick cycle
    c = cyc; run_req = 1'b1;
    expect_tick(c + 2); expect_tick(c + 4); expect_tick(c + 6);
    tick1(); run_req = 1'b0;
    check("run_entry_state", state, 2'b01);
    step_to(c + 6); halt_req = 1'b1;
    tick1(); halt_req = 1'b0;
    check("halt_after_tick_state", state, 2'b00);
    drain("sb_empty_run2");
    check("count_after_3", cycle_count, CNT_EN ? 32'd3 : 32'd0);

    // Divisor 5; cfg refused during RUN; mid-period halt
    cfg_div = 28'd5; cfg_valid = 1'b1;
    check("cfg_ready_halt", cfg_ready, 1);
    tick1(); cfg_valid = 1'b0;
    c = cyc; run_req = 1'b1;
    expect_tick(c + 5); expect_tick(c + 10);
    tick1(); run_req = 1'b0;
    step_to(c + 3); cfg_div = 28'd7; cfg_valid = 1'b1;
    check("cfg_ready_run", cfg_ready, 0);
    tick1(); cfg_valid = 1'b0;
    step_to(c + 12); halt_req = 1'b1;
    tick1(); halt_req = 1'b0;
    check("halt_mid_state", state, 2'b00);
    c = cyc; run_req = 1'b1;
    expect_tick(c + 5);
    tick1(); run_req = 1'b0;
    step_to(c + 5); halt_req = 1'b1;
    tick1(); halt_req = 1'b0;
    drain("sb_empty_div5");

    // Single step with divisor 3, run edge ignored while stepping
    load_div(28'd3);
    c = cyc; step_req = 1'b1;
    expect_tick(c + 3);
    tick1(); step_req = 1'b0;
    check("step_entry_state", state, 2'b10);
    run_req = 1'b1;
    tick1(); run_req = 1'b0;
    check("step_ignores_run", state, 2'b10);
    step_to(c + 4);
    check("step_return_halt", state, 2'b00);
    c = cyc; step_req = 1'b1;
    expect_tick(c + 3);
    tick1(); step_req = 1'b0;
    step_to(c + 5);
    check("step2_return_halt", state, 2'b00);
    drain("sb_empty_step");

    // Simultaneous edges: halt wins; then halt at counter 1 of 4
    halt_req = 1'b1; step_req = 1'b1; run_req = 1'b1;
    tick1();
    check("priority_halt_state", state, 2'b00);
    halt_req = 1'b0; step_req = 1'b0; run_req = 1'b0;
    tick1(); tick1();
    load_div(28'd4);
    c = cyc; run_req = 1'b1;
    tick1(); run_req = 1'b0;
    step_to(c + 2); halt_req = 1'b1;
    tick1(); halt_req = 1'b0;
    check("halt_cnt1_state", state, 2'b00);
    c = cyc; run_req = 1'b1;
    expect_tick(c + 4);
    tick1(); run_req = 1'b0;
    step_to(c + 4); halt_req = 1'b1;
    tick1(); halt_req = 1'b0;
    drain("sb_empty_div4");

    // Divisor 0 ticks every cycle; counter wrap
`ifdef CLK_STEP_CYCLE_CNT_EN
    force dut.r_cycle_count = 32'hFFFF_FFFE;
    #2;
    release dut.r_cycle_count;
    exp_cnt = 32'hFFFF_FFFE;
`endif
    load_div(28'd0);
    c = cyc; run_req = 1'b1;
    expect_tick(c + 1); expect_tick(c + 2);
    tick1(); run_req = 1'b0;
    step_to(c + 2); halt_req = 1'b1;
    tick1(); halt_req = 1'b0;
    check("div0_halt_state", state, 2'b00);
    drain("sb_empty_div0");
    check("count_wrap", cycle_count, CNT_EN ? exp_cnt : 32'd0);

    // Reset mid-run with run_req held
    load_div(28'd6);
    c = cyc; run_req = 1'b1;
    tick1();
    check("pre_rst_state", state, 2'b01);
    tick1(); tick1();
    rst = 1'b1;
    #1;
    check("async_rst_state", state, 2'b00);
    check("async_rst_tick", tick, 0);
    exp_cnt = '0;
    tick1();
    rst = 1'b0;
    repeat (3) tick1();
    check("held_run_no_entry", state, 2'b00);
    check("post_rst_cfg_ready", cfg_ready, 1);
    check("post_rst_count", cycle_count, 0);
    run_req = 1'b0;
    tick1();
    c = cyc; run_req = 1'b1;
    expect_tick(c + 2);
    tick1(); run_req = 1'b0;
    check("rerun_state", state, 2'b01);
    step_to(c + 2); halt_req = 1'b1;
    tick1(); halt_req = 1'b0;
    drain("sb_empty_post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter DEFAULT_DIV, default 28'd2, divisor value loaded into the divisor register at reset.
REQ-002 Port clock_in  input  1  system clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port run_req  input  1  level request to free-run; synchronous to clock_in.
REQ-005 Port halt_req  input  1  level request to halt; synchronous to clock_in.
REQ-006 Port step_req  input  1  level request for a single tick; synchronous to clock_in.
REQ-007 Port cfg_div  input  28  new divisor value.
REQ-008 Port cfg_valid  input  1  cfg_div is valid.
REQ-009 Port cfg_ready  output  1  controller accepts cfg_div this cycle.
REQ-010 Port tick  output  1  one-clock_in-cycle core clock-enable pulse, once per divided period.
REQ-011 Port state  output  2  current state: 00 HALT, 01 RUN, 10 STEP.
REQ-012 Port cycle_count  output  32  number of tick pulses issued since reset.

Function
REQ-013 Requests SHALL act on rising edges only: each request registered, edge = req & ~req_prev; edge seen in cycle N changes state at the clock edge ending cycle N.
REQ-014 Simultaneous edges SHALL resolve by priority halt > step > run.
REQ-015 HALT: run edge -> RUN; step edge -> STEP; otherwise stay; tick held 0; phase counter held at 0.
REQ-016 RUN: halt edge -> HALT; step and run edges ignored.
REQ-017 STEP: after exactly one tick, state returns to HALT on the same clock edge that ends the tick cycle; halt edge before that tick -> HALT with no tick; run and step edges ignored.
REQ-018 Phase counter (28-bit) SHALL count 0..D-1 in RUN and STEP, D = effective divisor; tick = 1 in the cycle counter == D-1, and the counter wraps to 0 on the next edge.
REQ-019 Effective divisor D = div_r, except div_r of 0 or 1 gives D = 1 (tick every cycle in RUN).
REQ-020 From HALT, the first tick SHALL occur D cycles after entry to RUN or STEP (counter starts at 0).
REQ-021 cfg_ready = 1 only when state == HALT; div_r <= cfg_div on a cycle with cfg_valid & cfg_ready; the new value is used from the next RUN/STEP entry.
REQ-022 A cfg transfer in the same cycle as a run/step edge SHALL still load div_r, and the new D SHALL govern the period just entered.
REQ-023 Leaving RUN on a halt edge SHALL abandon the partial period: counter to 0, no tick in the transition cycle unless the counter was already D-1 (that tick is issued).
REQ-024 cycle_count SHALL increment by 1 on every cycle with tick = 1 and wrap from 32'hFFFFFFFF to 0.
REQ-025 tick SHALL be combinational from state and counter only (no input-to-output path); all other outputs are registered or decoded from registered state.

Reset
REQ-026 On rst: state = HALT, phase counter = 0, div_r = DEFAULT_DIV, cycle_count = 0, tick = 0, cfg_ready = 1.
REQ-027 Request history registers SHALL reset to 1, so a request held high across reset release generates no edge.
REQ-028 rst asserted mid-RUN or mid-STEP SHALL abort immediately, with no tick after rst rises.

Configuration
REQ-029 Macro CLK_STEP_CYCLE_CNT_EN: when defined, the cycle_count counter is implemented per REQ-024; when undefined, cycle_count is tied to 32'd0 and no counter flops exist; all other behaviour is identical.

Verification
REQ-030 Reset, DEFAULT_DIV=2, run_req pulse -> state 01 next cycle; tick on cycles 2,4,6... after entry; cycle_count 1,2,3.
REQ-031 In HALT, cfg_div=5 with cfg_valid=1 -> accepted (cfg_ready=1); run edge -> ticks every 5 cycles; cfg_valid during RUN -> cfg_ready=0, div_r unchanged.
REQ-032 HALT, div=3, step_req pulse -> STEP; exactly one tick 3 cycles later; state back to 00; a second step pulse gives exactly one more tick.
REQ-033 halt_req, step_req and run_req rising together in HALT -> stays HALT, no tick; halt_req mid-period at counter 1 of 4 -> HALT, no tick, counter 0.
REQ-034 cfg_div=0 then run -> tick high every cycle; cycle_count preset by forcing to 32'hFFFFFFFE, two ticks -> wraps to 0.
REQ-035 rst pulsed mid-RUN with run_req held high -> state HALT, div_r=2, count 0, no RUN re-entry until run_req falls and rises again.
